// File: rtl/reg_generic_pkg.sv
// Shared defaults for the generic storage register used across the LX32 core.
package reg_generic_pkg;

    // Default data width when an instantiator does not pass its own (typically XLEN).
    localparam int DefaultWidth = 32;

endpackage

// File: rtl/reg_generic.sv
// Parameterised edge-triggered storage register with write enable and asynchronous
// active-high reset; data_out is driven straight from the flops.
module reg_generic
    import reg_generic_pkg::*;
#(
    parameter int               WIDTH       = DefaultWidth,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    if (WIDTH < 1) begin : g_width_check
        $fatal(1, "reg_generic: WIDTH must be at least 1");
    end

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (en) begin
            data_d = data_in;
        end
    end

    // Reset wins over enable because it sits in the sensitivity list and is tested first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_out = data_q;

`ifndef SYNTHESIS
    a_en_known : assert property (@(posedge clk) disable iff (rst) !$isunknown(en))
        else $error("reg_generic: en is X/Z at clock edge");

    a_reset_value : assert property (@(posedge clk) rst |-> (data_out == RESET_VALUE))
        else $error("reg_generic: data_out differs from RESET_VALUE during reset");

    a_hold_stable : assert property (@(posedge clk) disable iff (rst) !en |=> $stable(data_out))
        else $error("reg_generic: data_out changed while en was low");
`endif

endmodule

// File: tb/tb_reg_generic.sv
// Scoreboard bench for reg_generic: two 16-bit instances (reset values 0000 and 8000)
// driven with identical stimulus and compared against a small behavioural model.
module tb_reg_generic;

    localparam int          W    = 16;
    localparam logic [15:0] Rv0  = 16'h0000;
    localparam logic [15:0] Rv1  = 16'h8000;

    typedef struct {
        string       tag;
        logic [15:0] e0;
        logic [15:0] e1;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic [W-1:0]  dout0;
    logic [W-1:0]  dout1;

    logic [15:0]   m0;
    logic [15:0]   m1;
    exp_t          sb[$];
    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    reg_generic #(
        .WIDTH      (W),
        .RESET_VALUE(Rv0)
    ) u_dut0 (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .data_in (data_in),
        .data_out(dout0)
    );

    reg_generic #(
        .WIDTH      (W),
        .RESET_VALUE(Rv1)
    ) u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .data_in (data_in),
        .data_out(dout1)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag);
        exp_t ent;
        ent.tag = tag;
        ent.e0  = m0;
        ent.e1  = m1;
        sb.push_back(ent);
    endtask

    task automatic pop_check();
        exp_t ent;
        if (sb.size() == 0) begin
            failures++;
            checks++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            ent = sb.pop_front();
            check_eq({ent.tag, "/rv0000"}, dout0, ent.e0);
            check_eq({ent.tag, "/rv8000"}, dout1, ent.e1);
        end
    endtask

    // Drive inputs while clk is low, model the edge, then compare just after it.
    task automatic clock_step(input string tag, input logic e, input logic [15:0] d);
        en      = e;
        data_in = d;
        if (rst) begin
            m0 = Rv0;
            m1 = Rv1;
        end else if (e) begin
            m0 = d;
            m1 = d;
        end
        push_exp(tag);
        @(posedge clk);
        #1;
        pop_check();
        @(negedge clk);
    endtask

    // Raise rst between edges and expect the outputs to clear before any clock edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        m0  = Rv0;
        m1  = Rv1;
        push_exp(tag);
        #1;
        pop_check();
        @(negedge clk);
    endtask

    initial begin
        m0 = '0;
        m1 = '0;
        #1;
        rst = 1'b1;
        m0  = Rv0;
        m1  = Rv1;
        push_exp("reset_initial");
        #1;
        pop_check();
        @(negedge clk);

        clock_step("reset_hold0", 1'b0, 16'h0000);
        clock_step("reset_hold1", 1'b0, 16'h0000);
        rst = 1'b0;
        clock_step("release_idle0", 1'b0, 16'h0000);
        clock_step("release_idle1", 1'b0, 16'h0000);

        clock_step("write_a5a5", 1'b1, 16'hA5A5);
        for (int i = 0; i < 3; i++) begin
            clock_step($sformatf("hold_ffff%0d", i), 1'b0, 16'hFFFF);
        end

        async_reset("async_mid");
        clock_step("rst_en_pri0", 1'b1, 16'h1234);
        clock_step("rst_en_pri1", 1'b1, 16'h1234);
        rst = 1'b0;

        clock_step("b2b_0001", 1'b1, 16'h0001);
        clock_step("b2b_0002", 1'b1, 16'h0002);
        clock_step("b2b_ffff", 1'b1, 16'hFFFF);

        clock_step("load_0f0f", 1'b1, 16'h0F0F);
        clock_step("hold_ignore", 1'b0, 16'h5555);

        for (int i = 0; i < 8; i++) begin
            logic [15:0] r;
            logic        e;
            r = 16'($urandom);
            e = 1'($urandom_range(0, 1));
            clock_step($sformatf("rand%0d", i), e, r);
        end

        async_reset("async_final");
        rst = 1'b0;
        clock_step("final_idle", 1'b0, 16'hBEEF);

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
